// File: rtl/gpr_wb_ctl_pkg.sv
// Shared constants for the GPR write-back controller: widths, source count and
// the source indices used by the arbiter and the top level.
package gpr_wb_ctl_pkg;

   localparam int GPR_ADR_W  = 5;
   localparam int GPR_DAT_W  = 32;
   localparam int NUM_WB_SRC = 3;

   typedef enum logic [1:0] {
      WB_ALU = 2'd0,
      WB_LSU = 2'd1,
      WB_SPR = 2'd2
   } wb_src_e;

   typedef logic [NUM_WB_SRC-1:0] wb_grant_t;

   // Next source in the 0->1->2->0 rotation.
   function automatic logic [1:0] wb_next_src(input logic [1:0] src);
      return (src == 2'(NUM_WB_SRC - 1)) ? 2'd0 : src + 2'd1;
   endfunction

endpackage

// File: rtl/gpr_wb_ctl_if.sv
// Bundle of write-back requests, the GPR write port and the three read ports
// seen by the write-back controller.
interface gpr_wb_ctl_if
   import gpr_wb_ctl_pkg::*;
#(
   parameter int ADR_W = GPR_ADR_W,
   parameter int DAT_W = GPR_DAT_W
) ();

   logic             src0_valid;
   logic             src0_ready;
   logic [ADR_W-1:0] src0_adr;
   logic [DAT_W-1:0] src0_dat;
   logic             src1_valid;
   logic             src1_ready;
   logic [ADR_W-1:0] src1_adr;
   logic [DAT_W-1:0] src1_dat;
   logic             src2_valid;
   logic             src2_ready;
   logic [ADR_W-1:0] src2_adr;
   logic [DAT_W-1:0] src2_dat;

   logic             wr_en_0;
   logic [ADR_W-1:0] wr_adr_0;
   logic [DAT_W-1:0] wr_dat_0;

   logic [ADR_W-1:0] rd_adr_0;
   logic [ADR_W-1:0] rd_adr_1;
   logic [ADR_W-1:0] rd_adr_2;
   logic [DAT_W-1:0] gpr_rd_dat_0;
   logic [DAT_W-1:0] gpr_rd_dat_1;
   logic [DAT_W-1:0] gpr_rd_dat_2;
   logic [DAT_W-1:0] rd_dat_0;
   logic [DAT_W-1:0] rd_dat_1;
   logic [DAT_W-1:0] rd_dat_2;

   logic [(2**ADR_W)-1:0] busy_vec;

   modport master (
      output src0_valid, src0_adr, src0_dat,
      output src1_valid, src1_adr, src1_dat,
      output src2_valid, src2_adr, src2_dat,
      output rd_adr_0, rd_adr_1, rd_adr_2,
      output gpr_rd_dat_0, gpr_rd_dat_1, gpr_rd_dat_2,
      input  src0_ready, src1_ready, src2_ready,
      input  wr_en_0, wr_adr_0, wr_dat_0,
      input  rd_dat_0, rd_dat_1, rd_dat_2,
      input  busy_vec
   );

   modport slave (
      input  src0_valid, src0_adr, src0_dat,
      input  src1_valid, src1_adr, src1_dat,
      input  src2_valid, src2_adr, src2_dat,
      input  rd_adr_0, rd_adr_1, rd_adr_2,
      input  gpr_rd_dat_0, gpr_rd_dat_1, gpr_rd_dat_2,
      output src0_ready, src1_ready, src2_ready,
      output wr_en_0, wr_adr_0, wr_dat_0,
      output rd_dat_0, rd_dat_1, rd_dat_2,
      output busy_vec
   );

endinterface

// File: rtl/gpr_wb_arb.sv
// Three-way write-back arbiter: round-robin from a rotating pointer, or fixed
// priority LSU > ALU > SPR. Produces a one-hot grant every cycle, never stalls.
module gpr_wb_arb
   import gpr_wb_ctl_pkg::*;
#(
   parameter bit RR_EN = 1'b1
) (
   input  logic      clk,
   input  logic      reset,
   input  wb_grant_t valid,
   output wb_grant_t grant
);

   wb_src_e    ptr;
   logic [1:0] idx;

   always_comb begin
      grant = '0;
      idx   = ptr;
      if (RR_EN) begin
         for (int i = 0; i < NUM_WB_SRC; i++) begin
            if (grant == '0 && valid[idx]) begin
               grant[idx] = 1'b1;
            end
            idx = wb_next_src(idx);
         end
      end else begin
         if (valid[WB_LSU]) begin
            grant[WB_LSU] = 1'b1;
         end else if (valid[WB_ALU]) begin
            grant[WB_ALU] = 1'b1;
         end else if (valid[WB_SPR]) begin
            grant[WB_SPR] = 1'b1;
         end
      end
   end

   // The pointer moves past whichever source just won; it is ignored in fixed mode.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr <= WB_ALU;
      end else if (grant[WB_ALU]) begin
         ptr <= WB_LSU;
      end else if (grant[WB_LSU]) begin
         ptr <= WB_SPR;
      end else if (grant[WB_SPR]) begin
         ptr <= WB_ALU;
      end
   end

endmodule

// File: rtl/gpr_wb_ctl.sv
// Write-back controller for the 32x32 GPR macro: arbitrates three write sources
// onto the single write port and bypasses same-edge writes into the read results.
module gpr_wb_ctl
   import gpr_wb_ctl_pkg::*;
#(
   parameter int ADR_W = GPR_ADR_W,
   parameter int DAT_W = GPR_DAT_W,
   parameter bit RR_EN = 1'b1
) (
   input logic         clk,
   input logic         reset,
   gpr_wb_ctl_if.slave bus
);

   localparam int NUM_GPR = 2 ** ADR_W;
   localparam int NUM_RD  = 3;

   wb_grant_t        req;
   wb_grant_t        grant;
   logic [ADR_W-1:0] src_adr [NUM_WB_SRC];
   logic [DAT_W-1:0] src_dat [NUM_WB_SRC];
   logic [ADR_W-1:0] sel_adr;
   logic [DAT_W-1:0] sel_dat;
   logic             stg_en;
   logic [ADR_W-1:0] stg_adr;
   logic [DAT_W-1:0] stg_dat;
   logic             wr_en;
   logic [ADR_W-1:0] rd_adr     [NUM_RD];
   logic [DAT_W-1:0] gpr_rd_dat [NUM_RD];
   logic [DAT_W-1:0] rd_dat     [NUM_RD];

   // Requests are masked during reset so no source sees an acceptance that gets dropped.
   assign req = {bus.src2_valid, bus.src1_valid, bus.src0_valid} & {NUM_WB_SRC{~reset}};

   assign src_adr[WB_ALU] = bus.src0_adr;
   assign src_adr[WB_LSU] = bus.src1_adr;
   assign src_adr[WB_SPR] = bus.src2_adr;
   assign src_dat[WB_ALU] = bus.src0_dat;
   assign src_dat[WB_LSU] = bus.src1_dat;
   assign src_dat[WB_SPR] = bus.src2_dat;

   gpr_wb_arb #(
      .RR_EN (RR_EN)
   ) u_arb (
      .clk   (clk),
      .reset (reset),
      .valid (req),
      .grant (grant)
   );

   assign bus.src0_ready = grant[WB_ALU];
   assign bus.src1_ready = grant[WB_LSU];
   assign bus.src2_ready = grant[WB_SPR];

   always_comb begin
      sel_adr = '0;
      sel_dat = '0;
      for (int n = 0; n < NUM_WB_SRC; n++) begin
         if (grant[n]) begin
            sel_adr = src_adr[n];
            sel_dat = src_dat[n];
         end
      end
   end

   // One-cycle staging register in front of the macro write port.
   always_ff @(posedge clk) begin
      if (reset) begin
         stg_en  <= 1'b0;
         stg_adr <= '0;
         stg_dat <= '0;
      end else begin
         stg_en <= |grant;
         if (|grant) begin
            stg_adr <= sel_adr;
            stg_dat <= sel_dat;
         end
      end
   end

   // A staged write seen together with reset is dropped rather than committed.
   assign wr_en        = stg_en & ~reset;
   assign bus.wr_en_0  = wr_en;
   assign bus.wr_adr_0 = stg_adr;
   assign bus.wr_dat_0 = stg_dat;
   assign bus.busy_vec = wr_en ? (NUM_GPR'(1) << stg_adr) : '0;

   assign rd_adr[0]     = bus.rd_adr_0;
   assign rd_adr[1]     = bus.rd_adr_1;
   assign rd_adr[2]     = bus.rd_adr_2;
   assign gpr_rd_dat[0] = bus.gpr_rd_dat_0;
   assign gpr_rd_dat[1] = bus.gpr_rd_dat_1;
   assign gpr_rd_dat[2] = bus.gpr_rd_dat_2;

   // The macro returns pre-write data for a same-edge read, so remember the write.
   for (genvar x = 0; x < NUM_RD; x++) begin : g_byp
      logic             byp;
      logic [DAT_W-1:0] byp_dat;

      always_ff @(posedge clk) begin
         if (reset) begin
            byp     <= 1'b0;
            byp_dat <= '0;
         end else begin
            byp     <= stg_en && (stg_adr == rd_adr[x]);
            byp_dat <= stg_dat;
         end
      end

      assign rd_dat[x] = byp ? byp_dat : gpr_rd_dat[x];
   end

   assign bus.rd_dat_0 = rd_dat[0];
   assign bus.rd_dat_1 = rd_dat[1];
   assign bus.rd_dat_2 = rd_dat[2];

endmodule

// File: tb/tb_gpr_wb_ctl.sv
// Bench for gpr_wb_ctl: a round-robin instance with a GPR macro model and an
// architectural register model, plus a fixed-priority instance.
module tb_gpr_wb_ctl;
   import gpr_wb_ctl_pkg::*;

   logic clk = 1'b0;
   logic reset_rr = 1'b1;
   logic reset_fp = 1'b1;
   always #5 clk = ~clk;

   gpr_wb_ctl_if bus ();
   gpr_wb_ctl_if bus_fp ();

   gpr_wb_ctl #(.ADR_W(5), .DAT_W(32), .RR_EN(1'b1)) dut (
      .clk   (clk),
      .reset (reset_rr),
      .bus   (bus)
   );

   gpr_wb_ctl #(.ADR_W(5), .DAT_W(32), .RR_EN(1'b0)) dut_fp (
      .clk   (clk),
      .reset (reset_fp),
      .bus   (bus_fp)
   );

   int total = 0;
   int bad = 0;

   // GPR macro model: registered reads return the value before a same-edge write.
   logic [31:0] mem [32] = '{default: 32'h0};
   always @(posedge clk) begin
      bus.gpr_rd_dat_0 <= mem[bus.rd_adr_0];
      bus.gpr_rd_dat_1 <= mem[bus.rd_adr_1];
      bus.gpr_rd_dat_2 <= mem[bus.rd_adr_2];
      if (bus.wr_en_0) mem[bus.wr_adr_0] <= bus.wr_dat_0;
   end

   // Architectural model: register contents, pending requests and the staged write.
   logic [31:0] shadow [32];
   bit          req_v [3];
   logic [4:0]  req_a [3];
   logic [31:0] req_d [3];
   logic [4:0]  rda [3];
   int          ptr;
   bit          stg_v;
   logic [4:0]  stg_a;
   logic [31:0] stg_d;
   logic [31:0] exp_rd [3];
   bit          exp_rd_ok;
   logic [2:0]  last_rdy;
   logic        last_wen;
   logic [31:0] last_wdat;
   logic [31:0] last_busy;

   function automatic int pick(input bit v[3], input int p, input bit rr);
      int order [3];
      if (rr) begin
         for (int k = 0; k < 3; k++) order[k] = (p + k) % 3;
      end else begin
         order[0] = 1; order[1] = 0; order[2] = 2;
      end
      for (int k = 0; k < 3; k++) if (v[order[k]]) return order[k];
      return -1;
   endfunction

   task automatic applyStimulus(input bit rst);
      reset_rr = rst;
      bus.src0_valid = req_v[0]; bus.src0_adr = req_a[0]; bus.src0_dat = req_d[0];
      bus.src1_valid = req_v[1]; bus.src1_adr = req_a[1]; bus.src1_dat = req_d[1];
      bus.src2_valid = req_v[2]; bus.src2_adr = req_a[2]; bus.src2_dat = req_d[2];
      bus.rd_adr_0 = rda[0]; bus.rd_adr_1 = rda[1]; bus.rd_adr_2 = rda[2];
   endtask

   task automatic clear_reqs();
      for (int s = 0; s < 3; s++) begin
         req_v[s] = 1'b0; req_a[s] = '0; req_d[s] = '0;
      end
   endtask

   // One clock of the round-robin instance, entered and left just after a falling edge.
   task automatic cycle_rr(input bit rst, output int g);
      logic [2:0]  exp_rdy;
      logic [31:0] exp_busy;
      logic [31:0] act_rd [3];
      bit          exp_wen;
      applyStimulus(rst);
      #1;
      g = rst ? -1 : pick(req_v, ptr, 1'b1);
      exp_rdy = (g < 0) ? 3'b000 : 3'(1 << g);
      exp_wen = stg_v && !rst;
      exp_busy = exp_wen ? (32'h1 << stg_a) : 32'h0;
      last_rdy = {bus.src2_ready, bus.src1_ready, bus.src0_ready};
      last_wen = bus.wr_en_0;
      last_wdat = bus.wr_dat_0;
      last_busy = bus.busy_vec;
      total++;
      if (last_rdy !== exp_rdy) begin
         bad++; $display("[TB] FAIL ready: got %b want %b", last_rdy, exp_rdy);
      end
      total++;
      if (last_wen !== exp_wen) begin
         bad++; $display("[TB] FAIL wr_en: got %b want %b", last_wen, exp_wen);
      end
      if (exp_wen) begin
         total++;
         if (bus.wr_adr_0 !== stg_a || last_wdat !== stg_d) begin
            bad++;
            $display("[TB] FAIL wr_port: got %0d/%h want %0d/%h", bus.wr_adr_0, last_wdat, stg_a, stg_d);
         end
      end
      total++;
      if (last_busy !== exp_busy) begin
         bad++; $display("[TB] FAIL busy_vec: got %h want %h", last_busy, exp_busy);
      end
      if (exp_rd_ok) begin
         act_rd[0] = bus.rd_dat_0; act_rd[1] = bus.rd_dat_1; act_rd[2] = bus.rd_dat_2;
         for (int x = 0; x < 3; x++) begin
            total++;
            if (act_rd[x] !== exp_rd[x]) begin
               bad++; $display("[TB] FAIL rd_dat_%0d: got %h want %h", x, act_rd[x], exp_rd[x]);
            end
         end
      end
      if (exp_wen) shadow[stg_a] = stg_d;
      for (int x = 0; x < 3; x++) exp_rd[x] = shadow[rda[x]];
      exp_rd_ok = 1'b1;
      if (rst) begin
         ptr = 0; stg_v = 1'b0;
      end else if (g >= 0) begin
         stg_v = 1'b1; stg_a = req_a[g]; stg_d = req_d[g];
         req_v[g] = 1'b0; ptr = (g + 1) % 3;
      end else begin
         stg_v = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_fixed();
      logic [2:0] rdy;
      bus_fp.rd_adr_0 = '0; bus_fp.rd_adr_1 = '0; bus_fp.rd_adr_2 = '0;
      bus_fp.gpr_rd_dat_0 = '0; bus_fp.gpr_rd_dat_1 = '0; bus_fp.gpr_rd_dat_2 = '0;
      bus_fp.src0_valid = 1'b1; bus_fp.src0_adr = 5'd1; bus_fp.src0_dat = 32'hA0;
      bus_fp.src1_valid = 1'b1; bus_fp.src1_adr = 5'd2; bus_fp.src1_dat = 32'hB1;
      bus_fp.src2_valid = 1'b1; bus_fp.src2_adr = 5'd3; bus_fp.src2_dat = 32'hC2;
      reset_fp = 1'b1;
      @(posedge clk); @(negedge clk);
      reset_fp = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         rdy = {bus_fp.src2_ready, bus_fp.src1_ready, bus_fp.src0_ready};
         total++;
         if (rdy !== 3'b010) begin
            bad++; $display("[TB] FAIL fp_prio: got %b want 010", rdy);
         end
         if (k > 0) begin
            total++;
            if (bus_fp.wr_en_0 !== 1'b1 || bus_fp.wr_adr_0 !== 5'd2 || bus_fp.wr_dat_0 !== 32'hB1) begin
               bad++; $display("[TB] FAIL fp_wr_lsu: got %b/%0d/%h want 1/2/b1",
                               bus_fp.wr_en_0, bus_fp.wr_adr_0, bus_fp.wr_dat_0);
            end
         end
         @(posedge clk); @(negedge clk);
      end
      bus_fp.src1_valid = 1'b0;
      #1;
      rdy = {bus_fp.src2_ready, bus_fp.src1_ready, bus_fp.src0_ready};
      total++;
      if (rdy !== 3'b001) begin
         bad++; $display("[TB] FAIL fp_alu: got %b want 001", rdy);
      end
      @(posedge clk); @(negedge clk);
      bus_fp.src0_valid = 1'b0;
      #1;
      rdy = {bus_fp.src2_ready, bus_fp.src1_ready, bus_fp.src0_ready};
      total++;
      if (rdy !== 3'b100 || bus_fp.wr_adr_0 !== 5'd1 || bus_fp.wr_dat_0 !== 32'hA0) begin
         bad++; $display("[TB] FAIL fp_spr: got %b/%0d/%h want 100/1/a0", rdy, bus_fp.wr_adr_0, bus_fp.wr_dat_0);
      end
      @(posedge clk); @(negedge clk);
      bus_fp.src2_valid = 1'b0;
      @(posedge clk); @(negedge clk);
   endtask

   task automatic test_reset();
      int g;
      clear_reqs();
      cycle_rr(1'b1, g);
      cycle_rr(1'b1, g);
      cycle_rr(1'b0, g);
      total++;
      if (bus.wr_en_0 !== 1'b0 || bus.wr_adr_0 !== 5'd0 || bus.wr_dat_0 !== 32'h0 || bus.busy_vec !== 32'h0) begin
         bad++; $display("[TB] FAIL reset_state: got %b/%0d/%h/%h want 0/0/0/0",
                         bus.wr_en_0, bus.wr_adr_0, bus.wr_dat_0, bus.busy_vec);
      end
   endtask

   task automatic test_single();
      int g;
      req_v[0] = 1'b1; req_a[0] = 5'd5; req_d[0] = 32'hDEADBEEF;
      cycle_rr(1'b0, g);
      total++;
      if (last_rdy !== 3'b001) begin
         bad++; $display("[TB] FAIL single_ready: got %b want 001", last_rdy);
      end
      total++;
      if (bus.wr_en_0 !== 1'b1 || bus.wr_adr_0 !== 5'd5 || bus.wr_dat_0 !== 32'hDEADBEEF ||
          bus.busy_vec !== 32'h20) begin
         bad++; $display("[TB] FAIL single_write: got %b/%0d/%h/%h want 1/5/deadbeef/20",
                         bus.wr_en_0, bus.wr_adr_0, bus.wr_dat_0, bus.busy_vec);
      end
      cycle_rr(1'b0, g);
   endtask

   task automatic test_round_robin();
      int g;
      cycle_rr(1'b1, g);
      for (int s = 0; s < 3; s++) begin
         req_v[s] = 1'b1; req_a[s] = 5'($urandom_range(10, 20)); req_d[s] = $urandom;
      end
      for (int k = 0; k < 6; k++) begin
         cycle_rr(1'b0, g);
         total++;
         if (last_rdy !== 3'(1 << (k % 3))) begin
            bad++; $display("[TB] FAIL rr_order_%0d: got %b want %b", k, last_rdy, 3'(1 << (k % 3)));
         end
         if (g >= 0) begin
            req_v[g] = 1'b1; req_a[g] = 5'($urandom_range(10, 20)); req_d[g] = $urandom;
         end
      end
      clear_reqs();
      cycle_rr(1'b0, g);
   endtask

   task automatic test_bypass();
      int g;
      req_v[0] = 1'b1; req_a[0] = 5'd7; req_d[0] = 32'h12345678;
      rda[0] = 5'd0; rda[1] = 5'd0; rda[2] = 5'd0;
      cycle_rr(1'b0, g);
      rda[0] = 5'd7; rda[1] = 5'd3; rda[2] = 5'd7;
      cycle_rr(1'b0, g);
      total++;
      if (bus.rd_dat_0 !== 32'h12345678 || bus.rd_dat_2 !== 32'h12345678 || bus.rd_dat_1 !== bus.gpr_rd_dat_1) begin
         bad++; $display("[TB] FAIL bypass: got %h/%h/%h want 12345678/%h/12345678",
                         bus.rd_dat_0, bus.rd_dat_1, bus.rd_dat_2, bus.gpr_rd_dat_1);
      end
      cycle_rr(1'b0, g);
   endtask

   task automatic test_reset_mid();
      int g;
      clear_reqs();
      req_v[2] = 1'b1; req_a[2] = 5'd9; req_d[2] = 32'hCAFE0009;
      rda[1] = 5'd9;
      cycle_rr(1'b0, g);
      cycle_rr(1'b1, g);
      total++;
      if (last_wen !== 1'b0 || last_busy !== 32'h0) begin
         bad++; $display("[TB] FAIL reset_drop: got %b/%h want 0/0", last_wen, last_busy);
      end
      for (int s = 0; s < 3; s++) begin
         req_v[s] = 1'b1; req_a[s] = 5'd20 + 5'(s); req_d[s] = $urandom;
      end
      cycle_rr(1'b0, g);
      total++;
      if (last_wen !== 1'b0 || last_rdy !== 3'b001) begin
         bad++; $display("[TB] FAIL reset_after: got %b/%b want 0/001", last_wen, last_rdy);
      end
      cycle_rr(1'b0, g);
      cycle_rr(1'b0, g);
      cycle_rr(1'b0, g);
   endtask

   task automatic test_same_addr();
      int g;
      clear_reqs();
      req_v[0] = 1'b1; req_a[0] = 5'd4; req_d[0] = 32'd1;
      cycle_rr(1'b0, g);
      req_v[1] = 1'b1; req_a[1] = 5'd4; req_d[1] = 32'd2;
      cycle_rr(1'b0, g);
      total++;
      if (last_wen !== 1'b1 || last_wdat !== 32'd1) begin
         bad++; $display("[TB] FAIL same_first: got %b/%h want 1/1", last_wen, last_wdat);
      end
      rda[0] = 5'd4;
      cycle_rr(1'b0, g);
      total++;
      if (last_wen !== 1'b1 || last_wdat !== 32'd2) begin
         bad++; $display("[TB] FAIL same_second: got %b/%h want 1/2", last_wen, last_wdat);
      end
      total++;
      if (bus.rd_dat_0 !== 32'd2) begin
         bad++; $display("[TB] FAIL same_read: got %h want 2", bus.rd_dat_0);
      end
      cycle_rr(1'b0, g);
   endtask

   task automatic test_random();
      int g;
      bit rst;
      for (int i = 0; i < 400; i++) begin
         for (int s = 0; s < 3; s++) begin
            if (!req_v[s] && $urandom_range(0, 2) == 0) begin
               req_v[s] = 1'b1;
               req_a[s] = 5'($urandom_range(0, (i % 2 == 0) ? 7 : 31));
               req_d[s] = $urandom;
            end
         end
         for (int x = 0; x < 3; x++) rda[x] = 5'($urandom_range(0, 7));
         rst = ($urandom_range(0, 60) == 0);
         cycle_rr(rst, g);
      end
   endtask

   initial begin
      for (int r = 0; r < 32; r++) shadow[r] = 32'h0;
      clear_reqs();
      for (int x = 0; x < 3; x++) rda[x] = '0;
      ptr = 0; stg_v = 1'b0; stg_a = '0; stg_d = '0; exp_rd_ok = 1'b0;
      applyStimulus(1'b1);
      test_fixed();
      test_reset();
      test_single();
      test_round_robin();
      test_bypass();
      test_reset_mid();
      test_same_addr();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
